// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock datapath.
package lock_pkg;

  localparam int unsigned DIGIT_W = 2;
  localparam logic [DIGIT_W-1:0] DIGIT_INVALID = 2'd3;

  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    CHECK   = 3'd1,
    OPEN    = 3'd2,
    PROG    = 3'd3,
    LOCKOUT = 3'd4
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered-level rising-edge detector; the reset value lets a level held
// through reset be treated as already seen.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= RST_VAL;
    else     d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/code_entry_checker.sv
// Assembles entered digits into a combination, checks it against the stored
// code and sequences unlock, lockout and code re-programming.
module code_entry_checker
  import lock_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned UNLOCK_CYCLES  = 100,
  parameter int unsigned LOCKOUT_CYCLES = 400,
  parameter logic [2*N_DIGITS-1:0] DEFAULT_CODE = 8'h26
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIGIT_W-1:0]          digit,
  input  logic                        enter,
  input  logic                        prog,
  output logic                        unlock,
  output logic                        alarm,
  output logic                        err,
  output logic                        prog_active,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx
);

  localparam int unsigned IDX_W  = $clog2(N_DIGITS);
  localparam int unsigned CODE_W = DIGIT_W * N_DIGITS;
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int unsigned TMR_W  = $clog2(max_u(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);

  state_e              state_q, state_nxt;
  logic [IDX_W-1:0]    idx_q, idx_nxt, idx_inc;
  logic [FAIL_W-1:0]   fail_q, fail_nxt;
  logic [TMR_W-1:0]    timer_q, timer_nxt;
  logic [CODE_W-1:0]   entry_q, entry_nxt, slot;
  logic [CODE_W-1:0]   code_q, code_nxt;
  logic                err_nxt;
  logic                rise;
  logic                last, slot_bad, entry_bad, tmr_done;

  rise_detect #(.RST_VAL(1'b1)) u_rise (
    .clk    (clk),
    .rst    (rst),
    .d      (enter),
    .rise_c (rise)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ENTRY;
    else     state_q <= state_nxt;
  end

  // Next-state and datapath updates
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    fail_nxt  = fail_q;
    timer_nxt = timer_q;
    entry_nxt = entry_q;
    code_nxt  = code_q;
    err_nxt   = 1'b0;
    slot      = entry_q;
    slot_bad  = 1'b0;
    entry_bad = 1'b0;

    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) slot[DIGIT_W*k +: DIGIT_W] = digit;
    end
    for (int k = 0; k < N_DIGITS; k++) begin
      if (slot[DIGIT_W*k +: DIGIT_W] == DIGIT_INVALID)    slot_bad  = 1'b1;
      if (entry_q[DIGIT_W*k +: DIGIT_W] == DIGIT_INVALID) entry_bad = 1'b1;
    end

    last     = (idx_q == IDX_W'(N_DIGITS - 1));
    idx_inc  = last ? '0 : IDX_W'(idx_q + IDX_W'(1));
    tmr_done = (timer_q == '0);

    case (state_q)
      ENTRY: begin
        if (rise) begin
          entry_nxt = slot;
          idx_nxt   = idx_inc;
          if (last) state_nxt = CHECK;
        end
      end

      CHECK: begin
        if (entry_q == code_q && !entry_bad) begin
          state_nxt = OPEN;
          fail_nxt  = '0;
          timer_nxt = TMR_W'(UNLOCK_CYCLES - 1);
        end else begin
          err_nxt = 1'b1;
          if (fail_q == FAIL_W'(MAX_FAIL - 1)) begin
            state_nxt = LOCKOUT;
            fail_nxt  = FAIL_W'(MAX_FAIL);
            timer_nxt = TMR_W'(LOCKOUT_CYCLES - 1);
          end else begin
            state_nxt = ENTRY;
            fail_nxt  = FAIL_W'(fail_q + FAIL_W'(1));
          end
        end
      end

      OPEN: begin
        // Expiry takes priority over a coincident rise
        if (tmr_done) begin
          state_nxt = ENTRY;
        end else if (rise && prog) begin
          state_nxt = PROG;
          timer_nxt = '0;
          idx_nxt   = '0;
        end else begin
          timer_nxt = TMR_W'(timer_q - TMR_W'(1));
        end
      end

      PROG: begin
        if (rise) begin
          entry_nxt = slot;
          idx_nxt   = idx_inc;
          if (last) begin
            state_nxt = ENTRY;
            idx_nxt   = '0;
            if (slot_bad) err_nxt  = 1'b1;
            else          code_nxt = slot;
          end
        end
      end

      LOCKOUT: begin
        if (tmr_done) begin
          state_nxt = ENTRY;
          fail_nxt  = '0;
          idx_nxt   = '0;
        end else begin
          timer_nxt = TMR_W'(timer_q - TMR_W'(1));
        end
      end

      default: state_nxt = ENTRY;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      fail_q      <= '0;
      timer_q     <= '0;
      entry_q     <= '0;
      code_q      <= DEFAULT_CODE;
      err         <= 1'b0;
      unlock      <= 1'b0;
      alarm       <= 1'b0;
      prog_active <= 1'b0;
    end else begin
      idx_q       <= idx_nxt;
      fail_q      <= fail_nxt;
      timer_q     <= timer_nxt;
      entry_q     <= entry_nxt;
      code_q      <= code_nxt;
      err         <= err_nxt;
      unlock      <= (state_nxt == OPEN);
      alarm       <= (state_nxt == LOCKOUT);
      prog_active <= (state_nxt == PROG);
    end
  end

  assign digit_idx = idx_q;

endmodule

// File: tb/tb_code_entry_checker.sv
// Scoreboard bench: stimulus predicts output pulses (kind, start cycle, length)
// from an attempt-level model; a monitor reconstructs pulses and compares.
module tb_code_entry_checker;

  localparam int unsigned UC   = 8;
  localparam int unsigned LC   = 16;
  localparam int          MAXF = 3;
  localparam logic [7:0]  DEF  = 8'h26;

  localparam int K_UNLOCK = 0;
  localparam int K_ALARM  = 1;
  localparam int K_ERR    = 2;
  localparam int K_PROG   = 3;

  typedef struct {
    int kind;
    int start;
    int len;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enter = 1'b0;
  logic       prog = 1'b0;
  logic [1:0] digit = 2'd0;
  logic       unlock, alarm, err, prog_active;
  logic [1:0] digit_idx;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];
  logic [7:0] m_code = DEF;
  int   m_fail = 0;

  code_entry_checker #(
    .N_DIGITS       (4),
    .MAX_FAIL       (3),
    .UNLOCK_CYCLES  (UC),
    .LOCKOUT_CYCLES (LC),
    .DEFAULT_CODE   (DEF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digit       (digit),
    .enter       (enter),
    .prog        (prog),
    .unlock      (unlock),
    .alarm       (alarm),
    .err         (err),
    .prog_active (prog_active),
    .digit_idx   (digit_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_UNLOCK: return "unlock";
      K_ALARM:  return "alarm";
      K_ERR:    return "err";
      default:  return "prog_active";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int k, input int s, input int l);
    ev_t e;
    e.kind = k; e.start = s; e.len = l;
    exp_q.push_back(e);
  endtask

  task automatic emit(input int k, input int s, input int l);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL event: got %s start=%0d len=%0d, required none", kname(k), s, l);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.start != s || e.len != l) begin
        n_bad++;
        $display("FAIL event: got %s start=%0d len=%0d, required %s start=%0d len=%0d",
                 kname(k), s, l, kname(e.kind), e.start, e.len);
      end
    end
  endtask

  // Monitor: turn output levels into (kind, start, length) pulses
  logic [3:0] prev = 4'd0;
  int st[4];
  always @(negedge clk) begin
    logic [3:0] cur;
    cur = {prog_active, err, alarm, unlock};
    for (int i = 0; i < 4; i++) begin
      if (cur[i] && !prev[i]) st[i] = cyc;
      if (!cur[i] && prev[i]) emit(i, st[i], cyc - st[i]);
    end
    prev = cur;
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  // One enter press; t returns the cycle in which the rise is seen
  task automatic press(input logic [1:0] d, input logic p, input int exp_idx, output int t);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #1;
    digit = d; prog = p; enter = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    enter = 1'b0;
    digit = 2'($urandom);
    prog  = 1'($urandom);
    if (exp_idx >= 0) chk("digit_idx", int'(digit_idx), exp_idx);
  endtask

  function automatic bit has_bad(input logic [7:0] s);
    logic [1:0] d;
    for (int k = 0; k < 4; k++) begin
      d = s[2*k +: 2];
      if (d == 2'd3) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic attempt(input logic [7:0] seq);
    int t, tn, done;
    for (int k = 0; k < 4; k++) press(seq[2*k +: 2], 1'($urandom), (k + 1) % 4, t);
    if (!has_bad(seq) && seq == m_code) begin
      push(K_UNLOCK, t + 2, UC);
      m_fail = 0;
      done = t + 2 + UC;
      if ($urandom_range(0, 1) == 1) press(2'($urandom), 1'b0, 0, tn);
    end else begin
      push(K_ERR, t + 2, 1);
      m_fail++;
      if (m_fail == MAXF) begin
        push(K_ALARM, t + 2, LC);
        m_fail = 0;
        done = t + 2 + LC;
        for (int j = 0; j < 3; j++)
          if (cyc + 3 <= t + 1 + LC) press(2'($urandom), 1'($urandom), 0, tn);
      end else begin
        done = t + 2;
      end
    end
    wait_until(done);
    chk("fail_cnt", int'(dut.fail_q), m_fail);
  endtask

  task automatic unlock_and_prog(input logic [7:0] nseq);
    int t, tp, tl;
    for (int k = 0; k < 4; k++) press(m_code[2*k +: 2], 1'($urandom), (k + 1) % 4, t);
    m_fail = 0;
    press(2'($urandom), 1'b1, 0, tp);
    push(K_UNLOCK, t + 2, tp - (t + 2) + 1);
    for (int k = 0; k < 4; k++) press(nseq[2*k +: 2], 1'($urandom), (k + 1) % 4, tl);
    push(K_PROG, tp + 1, tl - tp);
    if (has_bad(nseq)) push(K_ERR, tl + 1, 1);
    else               m_code = nseq;
    wait_until(tl + 2);
    chk("code", int'(dut.code_q), int'(m_code));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    m_code = DEF;
    m_fail = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [7:0] s;
    int r;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst unlock", int'(unlock), 0);
    chk("rst alarm", int'(alarm), 0);
    chk("rst err", int'(err), 0);
    chk("rst prog_active", int'(prog_active), 0);
    chk("rst digit_idx", int'(digit_idx), 0);
    chk("rst code", int'(dut.code_q), int'(DEF));

    attempt(8'h26);                 // correct code
    attempt(8'h66);                 // 2,1,2,1 -> err, fail_cnt 1
    attempt(8'h66);
    attempt(8'h24);                 // third consecutive miss -> lockout
    attempt(8'h26);                 // unlocks after lockout
    unlock_and_prog(8'h50);         // new code 0,0,1,1
    attempt(8'h26);                 // old code now fails
    attempt(8'h50);                 // new code unlocks

    // Reset after two digits restores index and default code
    press(2'd0, 1'b0, 1, t);
    press(2'd0, 1'b0, 2, t);
    do_reset();
    chk("mid rst digit_idx", int'(digit_idx), 0);
    chk("mid rst code", int'(dut.code_q), int'(DEF));

    unlock_and_prog(8'h5C);         // 0,3,1,1 rejected
    attempt(8'h26);

    // Enter held through and after reset is not a rise
    @(posedge clk); #1 enter = 1'b1;
    do_reset();
    repeat (3) @(posedge clk);
    #1 chk("held enter digit_idx", int'(digit_idx), 0);
    enter = 1'b0;
    attempt(8'h26);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        attempt(m_code);
      end else if (r < 7) begin
        s = 8'($urandom);
        attempt(s);
      end else if (r < 9) begin
        s = m_code;
        s[2*$urandom_range(0, 3) +: 2] = 2'($urandom);
        attempt(s);
      end else begin
        s = 8'($urandom);
        unlock_and_prog(s);
      end
    end

    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clk);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL event: got nothing, required %s start=%0d len=%0d",
               kname(e.kind), e.start, e.len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
